// File: rtl/bram_lsu_adapter.sv
// rtl/bram_lsu_adapter.sv - load/store unit adapter onto a 1-cycle-latency block RAM port
//
// Purpose: accepts byte/half/word load and store requests, drives a registered
// write-first RAM port with lane-positioned store data and byte enables, and
// returns aligned, extended load data two cycles after acceptance.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_req_*  / o_req_ready    request handshake plus addr, write, size, unsigned, wdata
//   o_rsp_*  / i_rsp_ready    response handshake plus rdata, error
//   o_mem_*  / i_mem_read_data RAM port: byte address, write data, byte enables, read data
module bram_lsu_adapter #(
  parameter int MEM_ADDR_WIDTH = 14
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_error,
  output logic [31:0] o_mem_byte_address,
  output logic [31:0] o_mem_write_data,
  output logic [3:0]  o_mem_byte_write_enable,
  input  logic [31:0] i_mem_read_data
);

  logic [1:0]  req_off;
  logic        req_illegal;
  logic        stall;
  logic        accept;

  logic        s1_valid_q, s1_valid_d;
  logic [1:0]  s1_off_q, s1_off_d;
  logic [1:0]  s1_size_q, s1_size_d;
  logic        s1_unsigned_q, s1_unsigned_d;
  logic        s1_write_q, s1_write_d;
  logic        s1_error_q, s1_error_d;
  logic [MEM_ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  logic [31:0] s1_byte_addr;
  logic [31:0] load_word;
  logic [31:0] load_data;

  always_comb begin
    req_off     = i_req_addr[1:0];
    req_illegal = (i_req_size == 2'd3)
               || (i_req_size == 2'd1 && req_off[0])
               || (i_req_size == 2'd2 && req_off != 2'd0);
    stall       = s1_valid_q && rsp_valid_q && !i_rsp_ready;
    o_req_ready = !stall && !i_rst;
    accept      = i_req_valid && o_req_ready;
  end

  // While S1 is held the RAM must keep re-reading its word so the read data
  // is still valid when S1 finally advances. Only the bits the RAM decodes
  // are kept; the lane offset lives in s1_off_q.
  always_comb begin
    s1_byte_addr = '0;
    s1_byte_addr[MEM_ADDR_WIDTH+1:2] = s1_addr_q;
    o_mem_byte_address = stall ? s1_byte_addr : i_req_addr;

    o_mem_byte_write_enable = 4'b0000;
    if (accept && i_req_write && !req_illegal) begin
      case (i_req_size)
        2'd0:    o_mem_byte_write_enable = 4'b0001 << req_off;
        2'd1:    o_mem_byte_write_enable = 4'b0011 << req_off;
        default: o_mem_byte_write_enable = 4'b1111;
      endcase
    end

    // Replicate narrow data across all lanes; the byte enables pick the lane.
    case (i_req_size)
      2'd0:    o_mem_write_data = {4{i_req_wdata[7:0]}};
      2'd1:    o_mem_write_data = {2{i_req_wdata[15:0]}};
      default: o_mem_write_data = i_req_wdata;
    endcase
  end

  always_comb begin
    load_word = i_mem_read_data >> {s1_off_q, 3'b000};
    case (s1_size_q)
      2'd0:    load_data = {{24{!s1_unsigned_q && load_word[7]}}, load_word[7:0]};
      2'd1:    load_data = {{16{!s1_unsigned_q && load_word[15]}}, load_word[15:0]};
      default: load_data = load_word;
    endcase
  end

  always_comb begin
    s1_valid_d    = s1_valid_q;
    s1_off_d      = s1_off_q;
    s1_size_d     = s1_size_q;
    s1_unsigned_d = s1_unsigned_q;
    s1_write_d    = s1_write_q;
    s1_error_d    = s1_error_q;
    s1_addr_d     = s1_addr_q;
    if (!stall) begin
      s1_valid_d    = accept;
      s1_off_d      = req_off;
      s1_size_d     = i_req_size;
      s1_unsigned_d = i_req_unsigned;
      s1_write_d    = i_req_write;
      s1_error_d    = req_illegal;
      s1_addr_d     = i_req_addr[MEM_ADDR_WIDTH+1:2];
    end

    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    if (s1_valid_q && !stall) begin
      rsp_valid_d = 1'b1;
      rsp_error_d = s1_error_q;
      rsp_rdata_d = (s1_error_q || s1_write_q) ? 32'h0 : load_data;
    end else if (i_rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // Metadata is only meaningful alongside s1_valid_q, so it needs no reset.
  always_ff @(posedge i_clk) begin
    s1_off_q      <= s1_off_d;
    s1_size_q     <= s1_size_d;
    s1_unsigned_q <= s1_unsigned_d;
    s1_write_q    <= s1_write_d;
    s1_error_q    <= s1_error_d;
    s1_addr_q     <= s1_addr_d;
  end

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_rdata = rsp_rdata_q;
  assign o_rsp_error = rsp_error_q;

endmodule
